// File: rtl/ide_pkg.sv
// ide_pkg: shared constants for the IDE command arbiter.
//   LBA_W / SEC_W : default widths of the LBA and sector-count fields
//   MAX_SEC       : largest sector count the IDE engine accepts in one command
//   IDLE/ISSUE/RUN: arbiter FSM state encoding
package ide_pkg;

  localparam int LBA_W = 48;
  localparam int SEC_W = 17;

  localparam logic [SEC_W-1:0] MAX_SEC = 17'h10000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin selector over NREQ request lines.
//   clk, pRST : clock, asynchronous active-high reset
//   req       : request vector
//   en        : when high, the current winner becomes the new last-grant pointer
//   grant     : one-hot winner (all zero when nothing requests)
//   idx       : index of the winner
//   any       : at least one request is pending
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            pRST,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] last;
  logic          found;
  int            cand;

  // Scan the requesters starting just after the last winner and wrapping
  // around, so the most recently served requester is considered last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

  assign grant = found ? (NREQ'(1) << idx) : '0;
  assign any   = found;

  // The pointer starts at the highest index so requester 0 wins the first
  // arbitration after reset; it moves on every enabled grant.
  always_ff @(posedge clk or posedge pRST) begin
    if (pRST)
      last <= IW'(NREQ - 1);
    else if (en && found)
      last <= idx;
  end

endmodule

// File: rtl/ide_cmd_arbiter.sv
// ide_cmd_arbiter: shares one IDE command interface between NREQ requesters.
//   clk, pRST       : clock, asynchronous active-high reset
//   req_valid       : per-requester request, held until req_ready
//   req_lba         : packed start LBA per requester (LBA_W each)
//   req_sec_count   : packed sector count per requester (SEC_W each)
//   req_nwr         : per-requester direction (0 write, 1 read)
//   req_ready       : one-cycle accept pulse
//   req_done        : one-cycle completion pulse
//   req_err         : one-cycle pulse on rejected count or ack timeout
//   IDE_busy        : engine busy, possibly asynchronous to clk
//   IDE_command     : command strobe, held until busy is seen or timeout
//   IDE_LBA, IDE_Sec_Count, IDE_nWR : command fields, stable until next issue
//   grant_id        : index of the current/last grant
//   active          : high from issue until done or timeout
module ide_cmd_arbiter #(
  parameter int NREQ        = 2,
  parameter int ACK_TIMEOUT = 1023,
  parameter int LBA_W       = ide_pkg::LBA_W,
  parameter int SEC_W       = ide_pkg::SEC_W
) (
  input  logic                    clk,
  input  logic                    pRST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*LBA_W-1:0]   req_lba,
  input  logic [NREQ*SEC_W-1:0]   req_sec_count,
  input  logic [NREQ-1:0]         req_nwr,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic [NREQ-1:0]         req_err,
  input  logic                    IDE_busy,
  output logic                    IDE_command,
  output logic [LBA_W-1:0]        IDE_LBA,
  output logic [SEC_W-1:0]        IDE_Sec_Count,
  output logic                    IDE_nWR,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active
);

  import ide_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic            busy_r;
  logic [1:0]      state;
  logic [CW-1:0]   ack_cnt;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            grant_en;
  logic [SEC_W-1:0] sel_cnt;
  logic            sel_bad;

  assign grant_en = (state == IDLE) && !busy_r && arb_any;
  assign sel_cnt  = req_sec_count[int'(arb_idx)*SEC_W +: SEC_W];
  assign sel_bad  = (sel_cnt == '0) || (sel_cnt > MAX_SEC);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .pRST  (pRST),
    .req   (req_valid),
    .en    (grant_en),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // IDE_busy may come from another clock domain, so it is registered once
  // and every decision below looks only at the registered copy.
  always_ff @(posedge clk or posedge pRST) begin
    if (pRST)
      busy_r <= 1'b0;
    else
      busy_r <= IDE_busy;
  end

  // Main command FSM. IDLE grants and validates one request; a bad sector
  // count is answered with ready+err and no command. ISSUE holds the strobe
  // until the engine shows busy or the ack window expires. RUN waits for
  // busy to drop and reports completion. Pulses default low every cycle.
  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) begin
      state         <= IDLE;
      ack_cnt       <= '0;
      IDE_command   <= 1'b0;
      IDE_LBA       <= '0;
      IDE_Sec_Count <= '0;
      IDE_nWR       <= 1'b1;
      req_ready     <= '0;
      req_done      <= '0;
      req_err       <= '0;
      grant_id      <= '0;
      active        <= 1'b0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= '0;
      case (state)
        IDLE: begin
          if (grant_en) begin
            grant_id  <= arb_idx;
            req_ready <= arb_grant;
            if (sel_bad) begin
              req_err <= arb_grant;
            end else begin
              IDE_LBA       <= req_lba[int'(arb_idx)*LBA_W +: LBA_W];
              IDE_Sec_Count <= sel_cnt;
              IDE_nWR       <= req_nwr[arb_idx];
              IDE_command   <= 1'b1;
              active        <= 1'b1;
              ack_cnt       <= '0;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (busy_r) begin
            IDE_command <= 1'b0;
            state       <= RUN;
          end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
            IDE_command <= 1'b0;
            req_err     <= NREQ'(1) << grant_id;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + CW'(1);
          end
        end
        RUN: begin
          if (!busy_r) begin
            req_done <= NREQ'(1) << grant_id;
            active   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_cmd_arbiter.sv
// tb_ide_cmd_arbiter: directed scenarios plus randomized traffic for
// ide_cmd_arbiter (NREQ=3, ACK_TIMEOUT=16), compared every cycle against a
// transaction-level model of the arbiter kept in this file.
module tb_ide_cmd_arbiter;

  localparam int N   = 3;
  localparam int ACK = 16;
  localparam int LW  = 48;
  localparam int SW  = 17;

  logic            clk = 1'b0;
  logic            pRST = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*LW-1:0] req_lba = '0;
  logic [N*SW-1:0] req_sec_count = '0;
  logic [N-1:0]    req_nwr = '0;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic            IDE_busy;
  logic            IDE_command;
  logic [LW-1:0]   IDE_LBA;
  logic [SW-1:0]   IDE_Sec_Count;
  logic            IDE_nWR;
  logic [1:0]      grant_id;
  logic            active;

  int checks = 0;
  int fails  = 0;

  logic [N-1:0] keep = '0;
  logic engBusy = 1'b0, forceBusy = 1'b0;
  logic engOn = 1'b0, engRandom = 1'b0;
  int   ackDelay = 1, busyLen = 4;

  assign IDE_busy = engBusy | forceBusy;

  ide_cmd_arbiter #(.NREQ(N), .ACK_TIMEOUT(ACK), .LBA_W(LW), .SEC_W(SW)) dut (
    .clk(clk), .pRST(pRST), .req_valid(req_valid), .req_lba(req_lba),
    .req_sec_count(req_sec_count), .req_nwr(req_nwr), .req_ready(req_ready),
    .req_done(req_done), .req_err(req_err), .IDE_busy(IDE_busy),
    .IDE_command(IDE_command), .IDE_LBA(IDE_LBA), .IDE_Sec_Count(IDE_Sec_Count),
    .IDE_nWR(IDE_nWR), .grant_id(grant_id), .active(active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state: what the arbiter must present, derived from the
  // request/ack/complete rules rather than from any state encoding.
  logic [N-1:0]  eReady = '0, eDone = '0, eErr = '0;
  logic          eCmd = 1'b0, eNwr = 1'b1, eActive = 1'b0;
  logic [LW-1:0] eLba = '0;
  logic [SW-1:0] eSec = '0;
  logic [1:0]    eGrant = '0;
  bit            mActive = 0, mAcked = 0, mBusyR = 0;
  int            mHeld = 0, mLast = N - 1, mG = 0;
  logic [SW-1:0] mCnt;

  task automatic modelReset();
    eReady = '0; eDone = '0; eErr = '0;
    eCmd = 1'b0; eNwr = 1'b1; eActive = 1'b0;
    eLba = '0; eSec = '0; eGrant = '0;
    mActive = 0; mAcked = 0; mBusyR = 0; mHeld = 0; mLast = N - 1;
  endtask

  // Advance the model at each clock edge from the inputs present there;
  // reset is applied asynchronously just like the hardware.
  initial begin
    forever begin
      @(posedge clk or posedge pRST);
      if (pRST) begin
        modelReset();
      end else begin
        eReady = '0; eDone = '0; eErr = '0;
        if (!mActive) begin
          if (!mBusyR && req_valid != '0) begin
            mG = -1;
            for (int k = 1; k <= N; k++) begin
              int c;
              c = (mLast + k) % N;
              if (mG < 0 && req_valid[c]) mG = c;
            end
            mLast  = mG;
            eGrant = 2'(mG);
            mCnt   = req_sec_count[mG*SW +: SW];
            eReady[mG] = 1'b1;
            if (mCnt == 0 || mCnt > 17'h10000) begin
              eErr[mG] = 1'b1;
            end else begin
              eLba = req_lba[mG*LW +: LW];
              eSec = mCnt;
              eNwr = req_nwr[mG];
              eCmd = 1'b1;
              mActive = 1; mAcked = 0; mHeld = 1;
            end
          end
        end else if (!mAcked) begin
          if (mBusyR) begin
            eCmd = 1'b0; mAcked = 1;
          end else if (mHeld == ACK) begin
            eCmd = 1'b0; eErr[eGrant] = 1'b1; mActive = 0;
          end else begin
            mHeld++;
          end
        end else if (!mBusyR) begin
          eDone[eGrant] = 1'b1; mActive = 0;
        end
        eActive = mActive;
        mBusyR  = IDE_busy;
      end
    end
  end

  // Compare every output against the model half a cycle after each edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("ide_command", IDE_command, eCmd);
      checkOutput("ide_lba", IDE_LBA, eLba);
      checkOutput("ide_sec_count", IDE_Sec_Count, eSec);
      checkOutput("ide_nwr", IDE_nWR, eNwr);
      checkOutput("req_ready", req_ready, eReady);
      checkOutput("req_done", req_done, eDone);
      checkOutput("req_err", req_err, eErr);
      checkOutput("grant_id", grant_id, eGrant);
      checkOutput("active", active, eActive);
      checkOutput("ready_onehot", $countones(req_ready) <= 1, 1);
      checkOutput("done_onehot", $countones(req_done) <= 1, 1);
      checkOutput("err_onehot", $countones(req_err) <= 1, 1);
    end
  end

  // IDE engine stand-in: on each new command strobe it waits a delay, then
  // shows busy for a while. It restarts only on a fresh rising strobe.
  initial begin
    int phase, cnt, len;
    logic prevCmd;
    phase = 0; cnt = 0; len = 0; prevCmd = 1'b0;
    forever begin
      @(negedge clk or posedge pRST);
      if (pRST) begin
        engBusy = 1'b0; phase = 0; prevCmd = 1'b0;
      end else begin
        case (phase)
          0: if (engOn && IDE_command && !prevCmd) begin
               if (engRandom) begin
                 cnt = $urandom_range(0, 20); len = $urandom_range(2, 10);
               end else begin
                 cnt = ackDelay; len = busyLen;
               end
               if (cnt == 0) begin engBusy = 1'b1; cnt = len; phase = 2; end
               else phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin engBusy = 1'b1; cnt = len; phase = 2; end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin engBusy = 1'b0; phase = 0; end
             end
        endcase
        prevCmd = IDE_command;
      end
    end
  end

  // Wall-clock guard so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (req_ready[i] && !keep[i]) req_valid[i] = 1'b0;
  endtask

  task automatic applyStimulus(input int i, input logic [LW-1:0] lba, input logic [SW-1:0] cnt, input logic nwr);
    req_lba[i*LW +: LW]       = lba;
    req_sec_count[i*SW +: SW] = cnt;
    req_nwr[i]                = nwr;
    req_valid[i]              = 1'b1;
  endtask

  // sel: 0 ready[b], 1 done[b], 2 command high, 3 command low, 4 inactive, 5 any ready
  task automatic waitSignal(input string name, input int sel, input int b, input int limit);
    bit ok;
    ok = 0;
    for (int n = 0; n < limit && !ok; n++) begin
      tick();
      case (sel)
        0: ok = req_ready[b];
        1: ok = req_done[b];
        2: ok = IDE_command;
        3: ok = !IDE_command;
        4: ok = !active;
        default: ok = (req_ready != '0);
      endcase
    end
    if (!ok) checkOutput({name, "_wait"}, 0, 1);
  endtask

  task automatic doReset();
    req_valid = '0; keep = '0;
    pRST = 1'b1;
    repeat (2) @(negedge clk);
    pRST = 1'b0;
  endtask

  initial begin
    int order[4];
    int nGrants, highCnt, doneCnt, n;
    bit cmdSeen;
    logic [SW-1:0] rc;

    doReset();
    checkOutput("reset_nwr", IDE_nWR, 1);
    checkOutput("reset_cmd", IDE_command, 0);

    $display("[TB] scenario 1: single write command");
    engOn = 1; ackDelay = 3; busyLen = 20;
    applyStimulus(0, 48'h1000, 17'h100, 1'b0);
    waitSignal("t1_ready", 0, 0, 20);
    checkOutput("t1_ready_vec", req_ready, 3'b001);
    checkOutput("t1_lba", IDE_LBA, 48'h1000);
    checkOutput("t1_sec", IDE_Sec_Count, 17'h100);
    checkOutput("t1_nwr", IDE_nWR, 0);
    checkOutput("t1_cmd", IDE_command, 1);
    waitSignal("t1_cmd_drop", 3, 0, 40);
    doneCnt = 0;
    repeat (40) begin tick(); if (req_done[0]) doneCnt++; end
    checkOutput("t1_done_count", doneCnt, 1);

    $display("[TB] scenario 2: alternating grants");
    doReset();
    engOn = 1; ackDelay = 1; busyLen = 8;
    keep = 3'b011;
    applyStimulus(0, 48'h2000, 17'h8, 1'b1);
    applyStimulus(1, 48'h3000, 17'h10, 1'b0);
    nGrants = 0;
    for (int c = 0; c < 300 && nGrants < 4; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (req_ready[i] && nGrants < 4) begin order[nGrants] = i; nGrants++; end
    end
    keep = '0; req_valid = '0;
    checkOutput("t2_grants", nGrants, 4);
    checkOutput("t2_order0", order[0], 0);
    checkOutput("t2_order1", order[1], 1);
    checkOutput("t2_order2", order[2], 0);
    checkOutput("t2_order3", order[3], 1);
    waitSignal("t2_idle", 4, 0, 100);

    $display("[TB] scenario 3: ack timeout");
    engOn = 0;
    applyStimulus(1, 48'h4000, 17'h20, 1'b1);
    waitSignal("t3_cmd", 2, 0, 10);
    highCnt = 1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!IDE_command) break;
      highCnt++;
      if (highCnt == 4) applyStimulus(0, 48'h4100, 17'h3, 1'b0);
      if (highCnt == 6) begin engOn = 1; ackDelay = 2; busyLen = 5; end
    end
    checkOutput("t3_high_cycles", highCnt, 16);
    checkOutput("t3_err", req_err, 3'b010);
    checkOutput("t3_active", active, 0);
    tick();
    checkOutput("t3_next_ready", req_ready, 3'b001);
    checkOutput("t3_next_grant", grant_id, 0);
    waitSignal("t3_done", 1, 0, 100);

    $display("[TB] scenario 4: sector count limits");
    ackDelay = 2; busyLen = 4;
    applyStimulus(2, 48'hABC, 17'h0, 1'b1);
    waitSignal("t4_zero_ready", 0, 2, 10);
    checkOutput("t4_zero_err", req_err, 3'b100);
    checkOutput("t4_zero_cmd", IDE_command, 0);
    applyStimulus(2, 48'hABD, 17'h10001, 1'b1);
    waitSignal("t4_over_ready", 0, 2, 10);
    checkOutput("t4_over_err", req_err, 3'b100);
    checkOutput("t4_over_cmd", IDE_command, 0);
    applyStimulus(2, 48'hABE, 17'h10000, 1'b1);
    waitSignal("t4_max_ready", 0, 2, 10);
    checkOutput("t4_max_err", req_err, 3'b000);
    checkOutput("t4_max_sec", IDE_Sec_Count, 17'h10000);
    checkOutput("t4_max_cmd", IDE_command, 1);
    waitSignal("t4_max_done", 1, 2, 60);

    $display("[TB] scenario 5: asynchronous reset during run");
    ackDelay = 1; busyLen = 30;
    applyStimulus(0, 48'h5555, 17'h40, 1'b1);
    waitSignal("t5_ready", 0, 0, 10);
    waitSignal("t5_run", 3, 0, 20);
    repeat (3) tick();
    @(posedge clk);
    #2 pRST = 1'b1;
    #1;
    checkOutput("t5_rst_cmd", IDE_command, 0);
    checkOutput("t5_rst_lba", IDE_LBA, 0);
    checkOutput("t5_rst_sec", IDE_Sec_Count, 0);
    checkOutput("t5_rst_nwr", IDE_nWR, 1);
    checkOutput("t5_rst_active", active, 0);
    checkOutput("t5_rst_grant", grant_id, 0);
    checkOutput("t5_rst_pulses", {req_ready, req_done, req_err}, 0);
    busyLen = 4;
    applyStimulus(0, 48'h5600, 17'h2, 1'b0);
    applyStimulus(1, 48'h5700, 17'h2, 1'b1);
    tick(); tick();
    pRST = 1'b0;
    waitSignal("t5_first", 5, 0, 10);
    checkOutput("t5_first_ready", req_ready, 3'b001);
    waitSignal("t5_done1", 1, 1, 200);

    $display("[TB] scenario 6: external busy blocks grants");
    busyLen = 3;
    forceBusy = 1'b1;
    repeat (3) tick();
    applyStimulus(0, 48'h6666, 17'h1, 1'b0);
    cmdSeen = 0;
    repeat (50) begin tick(); if (IDE_command) cmdSeen = 1; end
    checkOutput("t6_no_cmd", cmdSeen, 0);
    forceBusy = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick(); n++;
      if (IDE_command) break;
    end
    checkOutput("t6_latency", n, 2);
    waitSignal("t6_done", 1, 0, 50);

    $display("[TB] randomized traffic");
    engRandom = 1;
    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 9))
            0: rc = 17'h0;
            1: rc = 17'h10001 + 17'($urandom_range(0, 100));
            2: rc = 17'h10000;
            default: rc = 17'($urandom_range(1, 17'hFFFF));
          endcase
          applyStimulus(i, 48'({$urandom(), $urandom()}), rc, 1'($urandom_range(0, 1)));
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (100) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
